// File: rtl/conv_pu_param.sv
// conv_pu_param: KxK convolution unit producing LANES adjacent outputs per beat,
// accumulated over NUM_CH input channels, with optional ReLU and valid/ready flow control.
module conv_pu_param #(
   parameter int K          = 5,
   parameter int LANES      = 2,
   parameter int IFM_W      = 8,
   parameter int WGT_W      = 8,
   parameter int ACC_W      = 32,
   parameter int NUM_CH     = 6,
   parameter bit IFM_SIGNED = 1'b0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [K*(K+LANES-1)*IFM_W-1:0] in_ifm,
   input  logic [K*K*WGT_W-1:0]           in_weight,
   input  logic                           relu_en,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [LANES*ACC_W-1:0]         out_data,
   output logic                           out_ch_err
);
   localparam int ROW_W = K + LANES - 1;
   localparam int NPIX  = K * ROW_W;
   localparam int NTAP  = K * K;
   localparam int LVL   = $clog2(NTAP);
   localparam int NP    = 1 << LVL;
   localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef logic [ACC_W-1:0] word_t;

   localparam word_t         ZERO_W  = {ACC_W{1'b0}};
   localparam logic [CW-1:0] CH_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CH_LAST = CW'(NUM_CH - 1);
   localparam logic [CW-1:0] CH_ONE  = CW'(1);

   // Number of live partial sums at a given tree level (odd leftovers carried up).
   function automatic int live_cnt(input int lvl);
      int n;
      n = NTAP;
      for (int j = 0; j < lvl; j++) begin
         n = (n + 1) / 2;
      end
      return n;
   endfunction

   // Level 0 holds the products; level LVL entry 0 holds each lane's full dot-product.
   word_t                  tree_q [LVL+1][LANES][NP];
   word_t                  tree_d [LVL+1][LANES][NP];
   logic [LVL:0]           vld_q, vld_d;
   logic [LVL:0]           rl_q, rl_d;
   word_t                  acc_q [LANES];
   word_t                  acc_d [LANES];
   logic [CW-1:0]          ch_cnt_q, ch_cnt_d;
   logic                   relu_q, relu_d;
   logic                   out_valid_q, out_valid_d;
   logic [LANES*ACC_W-1:0] out_data_q, out_data_d;
   logic                   err_q;
   logic                   adv_s;

   // Next-state for multiply, adder tree and channel accumulation stages.
   always_comb begin
      logic [IFM_W-1:0]        raw;
      logic signed [IFM_W:0]   px;
      logic signed [WGT_W-1:0] wt;
      word_t                   tot;
      logic                    relu_s;
      int                      n;
      adv_s       = !out_valid_q || out_ready;
      tree_d      = tree_q;
      vld_d       = vld_q;
      rl_d        = rl_q;
      acc_d       = acc_q;
      ch_cnt_d    = ch_cnt_q;
      relu_d      = relu_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      raw         = {IFM_W{1'b0}};
      px          = {(IFM_W+1){1'b0}};
      wt          = {WGT_W{1'b0}};
      tot         = ZERO_W;
      relu_s      = 1'b0;
      n           = 0;
      if (adv_s) begin
         vld_d[0] = in_valid;
         rl_d[0]  = relu_en;
         for (int j = 1; j <= LVL; j++) begin
            vld_d[j] = vld_q[j-1];
            rl_d[j]  = rl_q[j-1];
         end
         // Pixels are stored MSB-first, so element e sits at the (NPIX-1-e)th slot.
         for (int l = 0; l < LANES; l++) begin
            for (int t = 0; t < NP; t++) begin
               if (t < NTAP) begin
                  raw = in_ifm[(NPIX - 1 - ((t / K) * ROW_W + (t % K) + l)) * IFM_W +: IFM_W];
                  px  = IFM_SIGNED ? {raw[IFM_W-1], raw} : {1'b0, raw};
                  wt  = in_weight[(NTAP - 1 - t) * WGT_W +: WGT_W];
                  tree_d[0][l][t] = ACC_W'(px) * ACC_W'(wt);
               end else begin
                  tree_d[0][l][t] = ZERO_W;
               end
            end
         end
         for (int j = 1; j <= LVL; j++) begin
            n = live_cnt(j - 1);
            for (int l = 0; l < LANES; l++) begin
               for (int i = 0; i < NP / 2; i++) begin
                  if (2 * i + 1 < n) begin
                     tree_d[j][l][i] = tree_q[j-1][l][2*i] + tree_q[j-1][l][2*i+1];
                  end else if (2 * i < n) begin
                     tree_d[j][l][i] = tree_q[j-1][l][2*i];
                  end else begin
                     tree_d[j][l][i] = ZERO_W;
                  end
               end
               for (int i = NP / 2; i < NP; i++) begin
                  tree_d[j][l][i] = ZERO_W;
               end
            end
         end
         if (vld_q[LVL]) begin
            relu_s = (ch_cnt_q == CH_ZERO) ? rl_q[LVL] : relu_q;
            relu_d = relu_s;
            for (int l = 0; l < LANES; l++) begin
               tot = (ch_cnt_q == CH_ZERO) ? tree_q[LVL][l][0] : acc_q[l] + tree_q[LVL][l][0];
               acc_d[l] = tot;
               if (ch_cnt_q == CH_LAST) begin
                  out_data_d[l*ACC_W +: ACC_W] = (relu_s && tot[ACC_W-1]) ? ZERO_W : tot;
               end else begin
                  out_data_d[l*ACC_W +: ACC_W] = out_data_q[l*ACC_W +: ACC_W];
               end
            end
            if (ch_cnt_q == CH_LAST) begin
               ch_cnt_d    = CH_ZERO;
               out_valid_d = 1'b1;
            end else begin
               ch_cnt_d    = ch_cnt_q + CH_ONE;
               out_valid_d = 1'b0;
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // State registers; holding during backpressure is encoded in the next-state logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j <= LVL; j++) begin
            for (int l = 0; l < LANES; l++) begin
               for (int i = 0; i < NP; i++) begin
                  tree_q[j][l][i] <= ZERO_W;
               end
            end
         end
         for (int l = 0; l < LANES; l++) begin
            acc_q[l] <= ZERO_W;
         end
         vld_q       <= {(LVL+1){1'b0}};
         rl_q        <= {(LVL+1){1'b0}};
         ch_cnt_q    <= CH_ZERO;
         relu_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= {(LANES*ACC_W){1'b0}};
         err_q       <= 1'b0;
      end else begin
         tree_q      <= tree_d;
         acc_q       <= acc_d;
         vld_q       <= vld_d;
         rl_q        <= rl_d;
         ch_cnt_q    <= ch_cnt_d;
         relu_q      <= relu_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         err_q       <= 1'b0;
      end
   end

   assign in_ready   = adv_s;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_ch_err = err_q;

endmodule

// File: tb/tb_conv_pu_param.sv
// Bench for conv_pu_param: a NUM_CH=6 unsigned unit against a channel-accumulating
// reference model, and a NUM_CH=1 signed-pixel unit for latency and sign handling.
module tb_conv_pu_param;
   localparam int K      = 5;
   localparam int LANES  = 2;
   localparam int ACC_W  = 32;
   localparam int NUM_CH = 6;
   localparam int ROW    = K + LANES - 1;
   localparam int IB     = K * ROW * 8;
   localparam int WB     = K * K * 8;
   localparam int DB     = LANES * ACC_W;
   localparam logic [ACC_W-1:0] NEG6375 = -32'sd6375;

   logic          clk, rst_n;
   logic          m_valid, m_in_ready, m_relu, m_out_valid, m_out_ready, m_err;
   logic [IB-1:0] m_ifm;
   logic [WB-1:0] m_wgt;
   logic [DB-1:0] m_out_data;
   logic          b_valid, b_in_ready, b_relu, b_out_valid, b_out_ready, b_err;
   logic [IB-1:0] b_ifm;
   logic [WB-1:0] b_wgt;
   logic [DB-1:0] b_out_data;

   int            checks, errors;
   int            mdl_cnt;
   bit            mdl_relu;
   longint        mdl_acc [LANES];
   logic [DB-1:0] exp_q [$];
   logic [DB-1:0] last_out;
   int            out_beats, stall_cnt, b0;
   bit            rnd_rdy, saw_stall, hold_pending, tk;

   conv_pu_param #(.NUM_CH(NUM_CH), .IFM_SIGNED(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(m_valid), .in_ready(m_in_ready),
      .in_ifm(m_ifm), .in_weight(m_wgt), .relu_en(m_relu), .out_valid(m_out_valid),
      .out_ready(m_out_ready), .out_data(m_out_data), .out_ch_err(m_err));

   conv_pu_param #(.NUM_CH(1), .IFM_SIGNED(1'b1)) u_dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_in_ready),
      .in_ifm(b_ifm), .in_weight(b_wgt), .relu_en(b_relu), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_data(b_out_data), .out_ch_err(b_err));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [IB-1:0] fill_ifm(input logic [7:0] v);
      return {(K*ROW){v}};
   endfunction

   function automatic logic [WB-1:0] fill_wgt(input logic [7:0] v);
      return {(K*K){v}};
   endfunction

   function automatic logic [IB-1:0] rand_ifm();
      logic [IB-1:0] r;
      for (int i = 0; i < K * ROW; i++) r[i*8 +: 8] = 8'($urandom);
      return r;
   endfunction

   function automatic logic [WB-1:0] rand_wgt();
      logic [WB-1:0] r;
      for (int i = 0; i < K * K; i++) r[i*8 +: 8] = 8'($urandom);
      return r;
   endfunction

   // Plain dot-product of lane l: unsigned pixel (r, c+l) times signed weight (r, c).
   function automatic longint lane_sum(input logic [IB-1:0] ifm, input logic [WB-1:0] w, input int l);
      longint s;
      int     px, wv;
      s = 0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            px = int'(ifm[(K*ROW - 1 - (r*ROW + c + l))*8 +: 8]);
            wv = int'(w[(K*K - 1 - (r*K + c))*8 +: 8]);
            if (wv > 127) wv -= 256;
            s += longint'(px) * longint'(wv);
         end
      end
      return s;
   endfunction

   task automatic model_accept(input logic [IB-1:0] ifm, input logic [WB-1:0] w, input logic relu);
      logic [DB-1:0]           e;
      logic signed [ACC_W-1:0] v;
      if (mdl_cnt == 0) begin
         mdl_relu = relu;
         for (int l = 0; l < LANES; l++) mdl_acc[l] = 0;
      end
      for (int l = 0; l < LANES; l++) mdl_acc[l] += lane_sum(ifm, w, l);
      mdl_cnt++;
      if (mdl_cnt == NUM_CH) begin
         for (int l = 0; l < LANES; l++) begin
            v = mdl_acc[l][ACC_W-1:0];
            if (mdl_relu && v < 0) v = '0;
            e[l*ACC_W +: ACC_W] = v;
         end
         exp_q.push_back(e);
         mdl_cnt = 0;
      end
   endtask

   // One clock of the main unit: pick out_ready, check handshakes, then cross the edge.
   task automatic cyc(output bit took);
      logic [DB-1:0] e;
      if (stall_cnt > 0) begin
         m_out_ready = 1'b0;
         stall_cnt--;
      end else if (rnd_rdy) m_out_ready = 1'($urandom_range(0, 1));
      else m_out_ready = 1'b1;
      #1;
      chk("in_ready_rule", m_in_ready, !m_out_valid || m_out_ready);
      chk("ch_err_zero", m_err, 1'b0);
      if (hold_pending) chk("hold_valid", m_out_valid, 1'b1);
      hold_pending = m_out_valid && !m_out_ready;
      if (m_valid && !m_in_ready) saw_stall = 1'b1;
      if (m_out_valid && m_out_ready) begin
         chk("expected_beat", exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_data", m_out_data, e);
         end
         last_out = m_out_data;
         out_beats++;
      end
      took = m_valid && m_in_ready;
      if (took) model_accept(m_ifm, m_wgt, m_relu);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [IB-1:0] ifm, input logic [WB-1:0] w, input logic relu);
      bit took;
      int n;
      took = 1'b0;
      n = 0;
      m_valid = 1'b1; m_ifm = ifm; m_wgt = w; m_relu = relu;
      while (!took && n < 100) begin
         cyc(took);
         n++;
      end
      chk("send_accepted", took, 1'b1);
      m_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      bit t;
      m_valid = 1'b0;
      repeat (n) cyc(t);
      chk("drained", exp_q.size(), 0);
   endtask

   // Single-channel signed unit: one beat, expect out_valid 7 cycles after transfer.
   task automatic b_beat(input logic [IB-1:0] ifm, input logic [WB-1:0] w, input logic relu,
                         input logic [ACC_W-1:0] exp_lane, input string tag);
      int lat;
      chk({tag, "_in_ready"}, b_in_ready, 1'b1);
      b_ifm = ifm; b_wgt = w; b_relu = relu; b_valid = 1'b1;
      @(posedge clk);
      #1;
      b_valid = 1'b0;
      lat = 1;
      while (!b_out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_latency"}, lat, 7);
      for (int l = 0; l < LANES; l++) chk({tag, "_lane"}, b_out_data[l*ACC_W +: ACC_W], exp_lane);
      chk({tag, "_err"}, b_err, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0; errors = 0; mdl_cnt = 0; mdl_relu = 1'b0; out_beats = 0;
      stall_cnt = 0; rnd_rdy = 1'b0; saw_stall = 1'b0; hold_pending = 1'b0; last_out = '0;
      rst_n = 1'b0;
      m_valid = 1'b0; m_relu = 1'b0; m_ifm = '0; m_wgt = '0; m_out_ready = 1'b1;
      b_valid = 1'b0; b_relu = 1'b0; b_ifm = '0; b_wgt = '0; b_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", m_out_valid, 1'b0);
      chk("rst_out_data", m_out_data, '0);
      chk("rst_ch_err", m_err, 1'b0);
      chk("rst_b_out_valid", b_out_valid, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      b_beat(fill_ifm(8'd1), fill_wgt(8'd1), 1'b0, 32'd25, "ones");
      b_beat(fill_ifm(8'hFF), fill_wgt(8'hFF), 1'b0, 32'd25, "signed_ff");
      b_beat(fill_ifm(8'd1), fill_wgt(8'hFF), 1'b0, -32'sd25, "signed_neg");
      b_beat(fill_ifm(8'd1), fill_wgt(8'hFF), 1'b1, 32'd0, "relu_each");

      send(fill_ifm(8'hFF), fill_wgt(8'hFF), 1'b0);
      for (int i = 1; i < NUM_CH; i++) send('0, '0, 1'b0);
      drain(20);
      chk("unsigned_ff", last_out, {NEG6375, NEG6375});

      b0 = out_beats;
      for (int i = 0; i < NUM_CH; i++) send(fill_ifm(8'd2), fill_wgt(8'd3), 1'b0);
      drain(20);
      chk("six_ch_one_beat", out_beats - b0, 1);
      chk("six_ch_value", last_out, {32'd900, 32'd900});

      send(fill_ifm(8'hFF), fill_wgt(8'hFF), 1'b1);
      for (int i = 1; i < NUM_CH; i++) send('0, '0, 1'(i % 2));
      drain(20);
      chk("relu_ch0_on", last_out, '0);
      send(fill_ifm(8'hFF), fill_wgt(8'hFF), 1'b0);
      for (int i = 1; i < NUM_CH; i++) send('0, '0, 1'b1);
      drain(20);
      chk("relu_ch0_off", last_out, {NEG6375, NEG6375});

      saw_stall = 1'b0;
      for (int i = 0; i < 4 * NUM_CH; i++) begin
         if (i == 10) stall_cnt = 10;
         send(rand_ifm(), rand_wgt(), 1'($urandom_range(0, 1)));
      end
      drain(40);
      chk("stall_seen", saw_stall, 1'b1);

      rnd_rdy = 1'b1;
      for (int i = 0; i < 4 * NUM_CH; i++) send(rand_ifm(), rand_wgt(), 1'($urandom_range(0, 1)));
      rnd_rdy = 1'b0;
      drain(40);

      for (int i = 0; i < 4; i++) send(fill_ifm(8'd2), fill_wgt(8'd3), 1'b0);
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", m_out_valid, 1'b0);
      chk("midreset_out_data", m_out_data, '0);
      mdl_cnt = 0;
      exp_q.delete();
      hold_pending = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      b0 = out_beats;
      for (int i = 0; i < NUM_CH; i++) send(fill_ifm(8'd1), fill_wgt(8'd1), 1'b0);
      drain(20);
      chk("after_reset_beats", out_beats - b0, 1);
      chk("after_reset_value", last_out, {32'd150, 32'd150});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
